path_delay_sampler: RTL and testbench

//  Launch/capture controller that sits directly in front of and behind a chained spy delay path.
//  - Drives pathInput with controlled transitions.
//  - Samples pathResult a programmable number of clocks after each launch.
//  - Counts trials where the path output had not yet settled to its expected value.
//  The error count over N trials is the delay measurement consumed by readout logic.

---
 rtl/path_delay_sampler.sv | 108 ++++++++++
 tb/tb_path_delay_sampler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/path_delay_sampler.sv
// rtl/path_delay_sampler.sv - launch/capture controller measuring settle errors of a spy delay path
module path_delay_sampler #(
    parameter int TRIALS_W      = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int DELAY_W       = 4,
    parameter bit INVERTING     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [TRIALS_W-1:0] numTrials,
    input  logic [DELAY_W-1:0]  captureDelay,
    output logic                pathInput,
    input  logic                pathResult,
    output logic                busy,
    output logic                done,
    output logic [TRIALS_W-1:0] errorCount,
    output logic                lastSample
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state;
    logic [SW-1:0]       settleCnt;
    logic [DELAY_W-1:0]  waitCnt;
    logic [TRIALS_W-1:0] trialCnt;
    logic [TRIALS_W-1:0] numTrialsQ;
    logic [DELAY_W-1:0]  captureDelayQ;
    logic                expected;
    logic                mismatch;

    assign mismatch = (pathResult != expected);

    // pathResult feeds lastSample/errorCount directly: a single capture flop with
    // no synchronizer, so metastability shows up as measurement noise by design.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            settleCnt     <= '0;
            waitCnt       <= '0;
            trialCnt      <= '0;
            numTrialsQ    <= '0;
            captureDelayQ <= '0;
            expected      <= 1'b0;
            pathInput     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            errorCount    <= '0;
            lastSample    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        numTrialsQ    <= numTrials;
                        captureDelayQ <= captureDelay;
                        errorCount    <= '0;
                        trialCnt      <= '0;
                        settleCnt     <= '0;
                        busy          <= 1'b1;
                        state         <= (numTrials == '0) ? S_DONE : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settleCnt == SW'(SETTLE_CYCLES - 1)) begin
                        settleCnt <= '0;
                        state     <= S_LAUNCH;
                    end else begin
                        settleCnt <= settleCnt + 1'b1;
                    end
                end
                S_LAUNCH: begin
                    pathInput <= ~pathInput;
                    expected  <= ~pathInput ^ INVERTING;
                    waitCnt   <= captureDelayQ;
                    state     <= (captureDelayQ == '0) ? S_CAPTURE : S_WAIT;
                end
                S_WAIT: begin
                    waitCnt <= waitCnt - 1'b1;
                    if (waitCnt == DELAY_W'(1))
                        state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    lastSample <= pathResult;
                    errorCount <= errorCount + {{(TRIALS_W-1){1'b0}}, mismatch};
                    trialCnt   <= trialCnt + 1'b1;
                    state      <= (trialCnt + 1'b1 == numTrialsQ) ? S_DONE : S_SETTLE;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_path_delay_sampler.sv
// tb/tb_path_delay_sampler.sv - directed self-checking bench for path_delay_sampler
module tb_path_delay_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] numTrials;
    logic [3:0]  captureDelay;
    logic        pathInput;
    logic        pathResult;
    logic        busy;
    logic        done;
    logic [15:0] errorCount;
    logic        lastSample;

    logic        startInv;
    logic        pathInputInv;
    logic        pathResultInv;
    logic        busyInv;
    logic        doneInv;
    logic [15:0] errorCountInv;
    logic        lastSampleInv;

    int          pathMode = 0;
    logic        delayedPath = 1'b0;
    int          toggles = 0;
    int          checks = 0;
    int          failures = 0;

    path_delay_sampler #(.TRIALS_W(16), .SETTLE_CYCLES(8), .DELAY_W(4), .INVERTING(0)) dut (
        .clk(clk), .rst(rst), .start(start), .numTrials(numTrials),
        .captureDelay(captureDelay), .pathInput(pathInput), .pathResult(pathResult),
        .busy(busy), .done(done), .errorCount(errorCount), .lastSample(lastSample)
    );

    path_delay_sampler #(.TRIALS_W(16), .SETTLE_CYCLES(8), .DELAY_W(4), .INVERTING(1)) dutInv (
        .clk(clk), .rst(rst), .start(startInv), .numTrials(numTrials),
        .captureDelay(captureDelay), .pathInput(pathInputInv), .pathResult(pathResultInv),
        .busy(busyInv), .done(doneInv), .errorCount(errorCountInv), .lastSample(lastSampleInv)
    );

    always #5 clk = ~clk;

    // Path models: ideal, 1.5-clock delay, and an inverting path (mismatched against INVERTING=0)
    always @(pathInput) begin
        #15;
        delayedPath = pathInput;
    end

    always @(pathInput) toggles++;

    always_comb begin
        pathResult = pathInput;
        if (pathMode == 1)
            pathResult = delayedPath;
        else if (pathMode == 2)
            pathResult = ~pathInput;
    end

    assign pathResultInv = ~pathInputInv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic runTrial(input bit sel, input logic [15:0] n, input logic [3:0] d,
                            input int injectAt, output int cycles, output int doneCount,
                            output logic busyAtDone);
        bit seen;
        @(negedge clk);
        numTrials    = n;
        captureDelay = d;
        if (sel) startInv = 1'b1; else start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        startInv = 1'b0;
        cycles     = 0;
        doneCount  = 0;
        seen       = 1'b0;
        busyAtDone = 1'bx;
        while (!seen && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (cycles == injectAt) begin
                start     = 1'b1;
                numTrials = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (sel ? doneInv : done) begin
                doneCount++;
                seen       = 1'b1;
                busyAtDone = sel ? busyInv : busy;
            end
        end
        start = 1'b0;
        if (!seen) cycles = -1;
        repeat (4) begin
            @(negedge clk);
            if (sel ? doneInv : done) doneCount++;
        end
    endtask

    int   cyc;
    int   dcnt;
    int   t0;
    logic bsy;

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        startInv     = 1'b0;
        numTrials    = '0;
        captureDelay = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_pathInput",  32'(pathInput),  32'd0);
        check("reset_busy",       32'(busy),       32'd0);
        check("reset_done",       32'(done),       32'd0);
        check("reset_errorCount", 32'(errorCount), 32'd0);
        check("reset_lastSample", 32'(lastSample), 32'd0);

        // Ideal path, 8 trials, no extra capture delay
        pathMode = 0;
        t0 = toggles;
        runTrial(1'b0, 16'd8, 4'd0, 0, cyc, dcnt, bsy);
        check("t1_cycles",     32'(cyc),          32'd81);
        check("t1_doneCount",  32'(dcnt),         32'd1);
        check("t1_busyAtDone", 32'(bsy),          32'd0);
        check("t1_errorCount", 32'(errorCount),   32'd0);
        check("t1_pathInput",  32'(pathInput),    32'd0);
        check("t1_toggles",    32'(toggles - t0), 32'd8);
        check("t1_lastSample", 32'(lastSample),   32'd0);

        // 1.5-clock path: too short a window fails every trial, one extra cycle passes all
        pathMode = 1;
        runTrial(1'b0, 16'd8, 4'd0, 0, cyc, dcnt, bsy);
        check("t2a_cycles",     32'(cyc),        32'd81);
        check("t2a_errorCount", 32'(errorCount), 32'd8);
        repeat (5) @(negedge clk);
        check("t2a_held",       32'(errorCount), 32'd8);
        runTrial(1'b0, 16'd8, 4'd1, 0, cyc, dcnt, bsy);
        check("t2b_cycles",     32'(cyc),        32'd89);
        check("t2b_errorCount", 32'(errorCount), 32'd0);

        // Zero trials: straight to DONE
        pathMode = 0;
        t0 = toggles;
        runTrial(1'b0, 16'd0, 4'd0, 0, cyc, dcnt, bsy);
        check("t3_cycles",     32'(cyc),          32'd1);
        check("t3_doneCount",  32'(dcnt),         32'd1);
        check("t3_errorCount", 32'(errorCount),   32'd0);
        check("t3_toggles",    32'(toggles - t0), 32'd0);

        // Start while busy must be ignored
        runTrial(1'b0, 16'd8, 4'd0, 20, cyc, dcnt, bsy);
        check("t4_cycles",     32'(cyc),        32'd81);
        check("t4_doneCount",  32'(dcnt),       32'd1);
        check("t4_errorCount", 32'(errorCount), 32'd0);

        // Reset during WAIT of trial 4 (captureDelay=3, 13 cycles per trial)
        pathMode = 2;
        dcnt = 0;
        @(negedge clk);
        numTrials    = 16'd8;
        captureDelay = 4'd3;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("t5_preErrorCount", 32'(errorCount), 32'd3);
        check("t5_preBusy",       32'(busy),       32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy",       32'(busy),       32'd0);
        check("t5_errorCount", 32'(errorCount), 32'd0);
        check("t5_pathInput",  32'(pathInput),  32'd0);
        check("t5_done",       32'(done),       32'd0);
        repeat (4) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("t5_noDone", 32'(dcnt), 32'd0);
        pathMode = 0;
        runTrial(1'b0, 16'd2, 4'd0, 0, cyc, dcnt, bsy);
        check("t5_rerunCycles", 32'(cyc),        32'd21);
        check("t5_rerunErrors", 32'(errorCount), 32'd0);

        // Inverting path against INVERTING=1 instance
        runTrial(1'b1, 16'd5, 4'd2, 0, cyc, dcnt, bsy);
        check("t6_cycles",     32'(cyc),           32'd61);
        check("t6_doneCount",  32'(dcnt),          32'd1);
        check("t6_errorCount", 32'(errorCountInv), 32'd0);
        check("t6_pathInput",  32'(pathInputInv),  32'd1);
        check("t6_lastSample", 32'(lastSampleInv), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
